// File: rtl/wave_gen_multi.sv
// wave_gen_multi: prescaled multi-mode DAC waveform source with boundary-synchronised reconfiguration
module wave_gen_multi #(
  parameter int          DATA_W  = 8,
  parameter int          DIV_W   = 16,
  parameter int unsigned DEF_DIV = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [DATA_W-1:0] wave_out,
  output logic              dac_strobe,
  output logic              period_start
);
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, pend_div_q, pend_div_d;
  logic [DATA_W:0]   phase_q, phase_d, phase_inc;
  logic [1:0]        mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic              pend_valid_q, pend_valid_d, strobe_q, strobe_d, pstart_q, pstart_d;
  logic [DATA_W-1:0] wave_q, wave_d;
  logic              step, at_end, bnd, apply;

  function automatic logic [DATA_W-1:0] samp(input logic [1:0] m, input logic [DATA_W:0] p);
    return m == 2'b00 ? p[DATA_W-1:0] :
           m == 2'b11 ? ~p[DATA_W-1:0] :
           m == 2'b01 ? (p[DATA_W] ? ~p[DATA_W-1:0] : p[DATA_W-1:0]) :
                        {DATA_W{p[DATA_W]}};
  endfunction

  always_comb begin
    step         = en && (cnt_q == div_q);
    // triangle and square run over the full phase range, saws over the low half
    at_end       = (mode_q[0] ^ mode_q[1]) ? &phase_q : &phase_q[DATA_W-1:0];
    bnd          = step && at_end;
    apply        = pend_valid_q && (bnd || !en);
    phase_inc    = phase_q + 1'b1;
    cnt_d        = step ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    phase_d      = step ? phase_inc : phase_q;
    wave_d       = step ? samp(mode_q, phase_inc) : wave_q;
    mode_d       = mode_q;
    div_d        = div_q;
    strobe_d     = step;
    pstart_d     = bnd;
    pend_valid_d = cfg_load || (pend_valid_q && !apply);
    pend_mode_d  = cfg_load ? cfg_mode : pend_mode_q;
    pend_div_d   = cfg_load ? cfg_div : pend_div_q;
    if (apply) begin
      mode_d  = pend_mode_q;
      div_d   = pend_div_q;
      phase_d = '0;
      cnt_d   = '0;
      wave_d  = samp(pend_mode_q, '0);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q        <= '0;
      phase_q      <= '0;
      mode_q       <= 2'b01;
      div_q        <= DIV_W'(DEF_DIV);
      pend_mode_q  <= '0;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      wave_q       <= '0;
      strobe_q     <= 1'b0;
      pstart_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      pend_mode_q  <= pend_mode_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      wave_q       <= wave_d;
      strobe_q     <= strobe_d;
      pstart_q     <= pstart_d;
    end
  end

  assign wave_out     = wave_q;
  assign dac_strobe   = strobe_q;
  assign period_start = pstart_q;
endmodule
